shape_polygon_area: RTL and testbench

Parametrised successor to the fixed-shape area unit. It accepts one polygon per valid/ready transaction, with up to NUM_PTS signed vertices and a runtime vertex count. It computes twice the enclosed area with the shoelace formula, one vertex pair per cycle through a single multiply pair, and returns the magnitude, orientation and an error flag on a valid/ready output. It sits between the shape message sink and downstream consumers of area results.

---
 rtl/shape_polygon_area_if.sv | 29 ++
 rtl/shape_polygon_area.sv | 123 ++++++++++++
 tb/tb_shape_polygon_area.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/shape_polygon_area_if.sv
// Polygon-in / area-out handshake bundle for shape_polygon_area.
// The master drives polygons and accepts results; the slave is the area unit.
interface shape_polygon_area_if #(
  parameter int NUM_PTS = 8,
  parameter int COORD_W = 16,
  parameter int CNT_W   = $clog2(NUM_PTS + 1),
  parameter int AREA_W  = 2 * COORD_W + $clog2(NUM_PTS) + 1
);
  logic                       in_valid;
  logic                       in_ready;
  logic [NUM_PTS*COORD_W-1:0] in_x;
  logic [NUM_PTS*COORD_W-1:0] in_y;
  logic [CNT_W-1:0]           in_count;
  logic                       out_valid;
  logic                       out_ready;
  logic [AREA_W-1:0]          out_area2;
  logic                       out_cw;
  logic                       out_err;

  modport master (
    output in_valid, in_x, in_y, in_count, out_ready,
    input  in_ready, out_valid, out_area2, out_cw, out_err
  );

  modport slave (
    input  in_valid, in_x, in_y, in_count, out_ready,
    output in_ready, out_valid, out_area2, out_cw, out_err
  );
endinterface

// File: rtl/shape_polygon_area.sv
// Shoelace twice-area of a polygon with up to NUM_PTS signed vertices,
// one vertex pair per cycle through a single multiply pair.
module shape_polygon_area #(
  parameter int NUM_PTS = 8,
  parameter int COORD_W = 16
) (
  input  logic                clk,
  input  logic                rstn,
  shape_polygon_area_if.slave bus
);
  localparam int CNT_W  = $clog2(NUM_PTS + 1);
  localparam int AREA_W = 2 * COORD_W + $clog2(NUM_PTS) + 1;
  localparam int ACC_W  = AREA_W + 1;
  localparam int TERM_W = 2 * COORD_W + 1;
  localparam int IDX_W  = (NUM_PTS > 1) ? $clog2(NUM_PTS) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, state_nxt;

  logic [NUM_PTS*COORD_W-1:0] x_r, y_r;
  logic [CNT_W-1:0]           cnt_r, idx;
  logic signed [ACC_W-1:0]    acc, acc_sum;
  logic signed [COORD_W-1:0]  xa [NUM_PTS];
  logic signed [COORD_W-1:0]  ya [NUM_PTS];
  logic [IDX_W-1:0]           cur, nxt;
  logic signed [COORD_W-1:0]  xc, yc, xn, yn;
  logic signed [2*COORD_W-1:0] prod_a, prod_b;
  logic signed [TERM_W-1:0]   term;
  logic                       accept, legal, last;
  logic [AREA_W-1:0]          area_r;
  logic                       cw_r, err_r;

  // Magnitude of the final sum; the shoelace bound keeps it within AREA_W bits.
  function automatic logic [AREA_W-1:0] magnitude(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] a;
    a = (v < 0) ? -v : v;
    return a[AREA_W-1:0];
  endfunction

  assign accept = bus.in_valid && bus.in_ready;
  assign legal  = (bus.in_count >= CNT_W'(3)) && (bus.in_count <= CNT_W'(NUM_PTS));
  assign last   = (idx == cnt_r - CNT_W'(1));
  assign cur    = idx[IDX_W-1:0];

  always_comb begin
    for (int i = 0; i < NUM_PTS; i++) begin
      xa[i] = x_r[i*COORD_W +: COORD_W];
      ya[i] = y_r[i*COORD_W +: COORD_W];
    end
  end

  // The last edge wraps back to vertex 0 to close the polygon.
  always_comb begin
    nxt    = last ? '0 : cur + IDX_W'(1);
    xc     = xa[cur];
    yc     = ya[cur];
    xn     = xa[nxt];
    yn     = ya[nxt];
    prod_a = xc * yn;
    prod_b = xn * yc;
    term   = prod_a - prod_b;
    acc_sum = acc + term;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = legal ? ACCUM : DONE;
      ACCUM:   if (last) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = rstn && (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.out_area2 = area_r;
    bus.out_cw    = cw_r;
    bus.out_err   = err_r;
  end

  // Vertex storage is pure data and needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      x_r <= bus.in_x;
      y_r <= bus.in_y;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r  <= '0;
      idx    <= '0;
      acc    <= '0;
      area_r <= '0;
      cw_r   <= 1'b0;
      err_r  <= 1'b0;
    end else if (accept) begin
      cnt_r <= bus.in_count;
      idx   <= '0;
      acc   <= '0;
      if (!legal) begin
        area_r <= '0;
        cw_r   <= 1'b0;
        err_r  <= 1'b1;
      end
    end else if (state == ACCUM) begin
      acc <= acc_sum;
      idx <= idx + CNT_W'(1);
      if (last) begin
        area_r <= magnitude(acc_sum);
        cw_r   <= (acc_sum < 0);
        err_r  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_shape_polygon_area.sv
// Directed bench for shape_polygon_area: hand-computed shoelace areas,
// latency, error counts, backpressure and mid-computation reset.
module tb_shape_polygon_area;
  localparam int NP    = 8;
  localparam int CW    = 16;
  localparam int CW8   = 8;
  localparam int CNT_W = $clog2(NP + 1);

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  shape_polygon_area_if #(.NUM_PTS(NP), .COORD_W(CW))  bus  ();
  shape_polygon_area_if #(.NUM_PTS(NP), .COORD_W(CW8)) bus8 ();

  shape_polygon_area #(.NUM_PTS(NP), .COORD_W(CW))  dut  (.clk(clk), .rstn(rstn), .bus(bus));
  shape_polygon_area #(.NUM_PTS(NP), .COORD_W(CW8)) dut8 (.clk(clk), .rstn(rstn), .bus(bus8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    for (int i = 0; i < NP; i++) begin
      bus.in_x[i*CW +: CW] = CW'($urandom);
      bus.in_y[i*CW +: CW] = CW'($urandom);
    end
    bus.in_count = CNT_W'($urandom);
  endtask

  task automatic sv(input int i, input int x, input int y);
    bus.in_x[i*CW +: CW] = CW'(x);
    bus.in_y[i*CW +: CW] = CW'(y);
  endtask

  task automatic sv8(input int i, input int x, input int y);
    bus8.in_x[i*CW8 +: CW8] = CW8'(x);
    bus8.in_y[i*CW8 +: CW8] = CW8'(y);
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, ".vld_drop"}, bus.out_valid, 0);
    chk({tag, ".rdy_back"}, bus.in_ready, 1);
  endtask

  // Submit the polygon currently on bus, then scramble the inputs so the
  // result must come from the latched copy.
  task automatic run(input string tag, input int n, input int exp_area,
                     input logic exp_cw, input logic exp_err, input int hold);
    int lat;
    int exp_lat;
    exp_lat = exp_err ? 1 : n + 1;
    chk({tag, ".rdy"}, bus.in_ready, 1);
    bus.in_count = CNT_W'(n);
    bus.in_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      if (lat == 0) begin
        bus.in_valid = 1'b0;
        scramble();
      end
      lat++;
    end while (!bus.out_valid && lat < 40);
    chk({tag, ".lat"},  lat, exp_lat);
    chk({tag, ".area"}, bus.out_area2, exp_area);
    chk({tag, ".cw"},   bus.out_cw, exp_cw);
    chk({tag, ".err"},  bus.out_err, exp_err);
    bus.in_count = CNT_W'(3);
    for (int k = 0; k < hold; k++) begin
      bus.in_valid = k[0];
      @(posedge clk); #1;
      chk({tag, ".hold_vld"},  bus.out_valid, 1);
      chk({tag, ".hold_area"}, bus.out_area2, exp_area);
      chk({tag, ".hold_rdy"},  bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    handshake(tag);
  endtask

  task automatic rect_ccw();
    scramble();
    sv(0, 0, 0); sv(1, 4, 0); sv(2, 4, 3); sv(3, 0, 3);
  endtask

  task automatic rect_cw();
    scramble();
    sv(0, 0, 3); sv(1, 4, 3); sv(2, 4, 0); sv(3, 0, 0);
  endtask

  initial begin
    int lat;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_x = '0; bus.in_y = '0; bus.in_count = '0;
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b0;
    bus8.in_x = '0; bus8.in_y = '0; bus8.in_count = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready",  bus.in_ready, 0);
    chk("rst.out_valid", bus.out_valid, 0);
    chk("rst.area",      bus.out_area2, 0);
    chk("rst.cw",        bus.out_cw, 0);
    chk("rst.err",       bus.out_err, 0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rst.rel_ready", bus.in_ready, 1);

    rect_ccw();
    run("rect_ccw", 4, 24, 1'b0, 1'b0, 0);
    rect_cw();
    run("rect_cw", 4, 24, 1'b1, 1'b0, 0);

    scramble();
    sv(0, 0, 0); sv(1, 10, 0); sv(2, 0, 10);
    run("tri", 3, 100, 1'b0, 1'b0, 0);
    scramble();
    sv(0, 0, 0); sv(1, 5, 0); sv(2, 10, 0); sv(3, 0, 10);
    run("tri_col", 4, 100, 1'b0, 1'b0, 0);

    scramble();
    sv(0, 0, 0); sv(1, 1, 1); sv(2, 2, 2);
    run("degen", 3, 0, 1'b0, 1'b0, 0);

    scramble();
    run("cnt2", 2, 0, 1'b0, 1'b1, 0);
    scramble();
    run("cnt9", 9, 0, 1'b0, 1'b1, 0);
    rect_ccw();
    run("after_err", 4, 24, 1'b0, 1'b0, 0);

    rect_cw();
    run("bp", 4, 24, 1'b1, 1'b0, 10);
    repeat (2) begin
      @(posedge clk); #1;
      chk("bp.no_accept", bus.out_valid, 0);
    end

    // Reset while the accumulator sits at idx 2.
    rect_ccw();
    bus.in_count = CNT_W'(4);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("midrst.out_valid", bus.out_valid, 0);
    chk("midrst.in_ready",  bus.in_ready, 0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("midrst.rel_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    chk("midrst.idle", bus.out_valid, 0);
    rect_cw();
    run("resubmit", 4, 24, 1'b1, 1'b0, 0);

    sv8(0, -128, -128); sv8(1, 127, -128); sv8(2, 127, 127); sv8(3, -128, 127);
    for (int i = 4; i < NP; i++) sv8(i, 100, -50);
    bus8.in_count = CNT_W'(4);
    bus8.in_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      lat++;
    end while (!bus8.out_valid && lat < 40);
    chk("ext.lat",  lat, 5);
    chk("ext.area", bus8.out_area2, 130050);
    chk("ext.cw",   bus8.out_cw, 0);
    chk("ext.err",  bus8.out_err, 0);
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    chk("ext.vld_drop", bus8.out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
